qos_vc_arbiter: RTL and testbench

Parametrised virtual-channel to main-FIFO transfer engine for the QoS module. Drains NCH first-word-fall-through virtual-channel FIFOs into the single main FIFO, one word per cycle. Channel selection is either an externally forced ID or burst-limited round-robin. Main-FIFO backpressure is honoured, and a registered push stage gives a clean one-cycle pipeline.

---
 rtl/qos_vc_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_qos_vc_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/qos_vc_arbiter.sv
// qos_vc_arbiter: drains NCH first-word-fall-through virtual-channel FIFOs into
// a single main FIFO, one word per cycle. The channel is either forced by ID_IN
// (MODE=0) or picked by burst-limited round-robin (MODE=1). A registered push
// stage gives exactly one cycle from pop to push.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   ENABLE              permits new pops
//   MODE                0 = forced ID_IN, 1 = round-robin
//   ID_IN               channel to drain in forced mode
//   VC_EMPTY, VC_DATA   per-channel empty flag and FWFT head word
//   MAIN_ALMOST_FULL    main FIFO has fewer than two free entries
//   MAIN_FULL           main FIFO has no free entry
//   VC_POP              combinational one-hot-or-zero pop
//   MAIN_PUSH/MAIN_DATA registered push and word to the main FIFO
//   CUR_ID              registered ID of the last granted channel
//   XFER_COUNT          registered count of completed pushes (wraps)
//   OVF_ERR             sticky: a push was presented while MAIN_FULL was high
module qos_vc_arbiter #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 4,
    parameter int unsigned IDW   = $clog2(NCH),
    parameter int unsigned BURST = 2,
    parameter int unsigned CW    = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              MODE,
    input  logic [IDW-1:0]    ID_IN,
    input  logic [NCH-1:0]    VC_EMPTY,
    input  logic [NCH*DW-1:0] VC_DATA,
    input  logic              MAIN_ALMOST_FULL,
    input  logic              MAIN_FULL,
    output logic [NCH-1:0]    VC_POP,
    output logic              MAIN_PUSH,
    output logic [DW-1:0]     MAIN_DATA,
    output logic [IDW-1:0]    CUR_ID,
    output logic [CW-1:0]     XFER_COUNT,
    output logic              OVF_ERR
);

    localparam int unsigned BCW = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_BURSTING  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  cur_q, cur_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic            push_q, push_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [CW-1:0]   xfer_q, xfer_d;
    logic            ovf_q, ovf_d;

    logic [NCH-1:0]  elig;
    logic            rr_hit;
    logic [IDW-1:0]  rr_idx;
    logic            grant;
    logic [IDW-1:0]  gnt_id;
    logic [DW-1:0]   gnt_word;

    // Eligibility; pops are suppressed while RESET is held so VC_POP reads 0.
    always_comb begin
        elig = ~VC_EMPTY & {NCH{ENABLE & ~MAIN_ALMOST_FULL & ~RESET}};
    end

    // Round-robin search starting at CUR+1. CUR itself is visited last, so it
    // only wins when it is the sole eligible channel. Iterating downward lets
    // the nearest hit overwrite farther ones.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int unsigned k = NCH; k >= 1; k--) begin
            idx = (32'(cur_q) + k) % NCH;
            if (elig[idx]) begin
                rr_hit = 1'b1;
                rr_idx = IDW'(idx);
            end
        end
    end

    // Grant decision and next-state logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        bcnt_d  = bcnt_q;
        grant   = 1'b0;
        gnt_id  = cur_q;

        if (!MODE) begin
            // Leaving round-robin parks the FSM; CUR is kept for later.
            state_d = S_IDLE;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (ID_IN == IDW'(i) && elig[i]) begin
                    grant  = 1'b1;
                    gnt_id = ID_IN;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rr_hit) begin
                        grant   = 1'b1;
                        gnt_id  = rr_idx;
                        cur_d   = rr_idx;
                        bcnt_d  = BCW'(1);
                        state_d = S_BURSTING;
                    end
                end
                S_BURSTING: begin
                    if (elig[cur_q] && (bcnt_q < BCW'(BURST))) begin
                        grant  = 1'b1;
                        gnt_id = cur_q;
                        bcnt_d = bcnt_q + BCW'(1);
                    end else if (rr_hit) begin
                        grant  = 1'b1;
                        gnt_id = rr_idx;
                        cur_d  = rr_idx;
                        bcnt_d = BCW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // One-hot pop and head-word mux for the granted channel.
    always_comb begin
        VC_POP   = '0;
        gnt_word = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt_id == IDW'(i)) begin
                VC_POP[i] = grant;
                gnt_word  = VC_DATA[i*DW +: DW];
            end
        end
    end

    // Push stage, counters and sticky overflow.
    always_comb begin
        push_d   = grant;
        data_d   = grant ? gnt_word : data_q;
        cur_id_d = grant ? gnt_id : cur_id_q;
        xfer_d   = xfer_q + CW'(push_q);
        ovf_d    = ovf_q | (push_q & MAIN_FULL);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cur_q    <= IDW'(NCH - 1);
            bcnt_q   <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            cur_id_q <= '0;
            xfer_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            bcnt_q   <= bcnt_d;
            push_q   <= push_d;
            data_q   <= data_d;
            cur_id_q <= cur_id_d;
            xfer_q   <= xfer_d;
            ovf_q    <= ovf_d;
        end
    end

    assign MAIN_PUSH  = push_q;
    assign MAIN_DATA  = data_q;
    assign CUR_ID     = cur_id_q;
    assign XFER_COUNT = xfer_q;
    assign OVF_ERR    = ovf_q;

endmodule

// File: tb/tb_qos_vc_arbiter.sv
// Directed testbench for qos_vc_arbiter (NCH=4, DW=4, BURST=2, CW=2).
// Small FWFT FIFO models feed the virtual channels; expected values are hand-computed.
module tb_qos_vc_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned CW  = 2;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              mode;
    logic [IDW-1:0]    id_in;
    logic [NCH-1:0]    vc_empty;
    logic [NCH*DW-1:0] vc_data;
    logic              main_af;
    logic              main_full;
    logic [NCH-1:0]    vc_pop;
    logic              main_push;
    logic [DW-1:0]     main_data;
    logic [IDW-1:0]    cur_id;
    logic [CW-1:0]     xfer_count;
    logic              ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fifo [NCH][8];
    int            rd   [NCH];
    int            wr   [NCH];

    qos_vc_arbiter #(
        .NCH(NCH), .DW(DW), .IDW(IDW), .BURST(2), .CW(CW)
    ) u_dut (
        .CLK              (clk),
        .RESET            (rst),
        .ENABLE           (enable),
        .MODE             (mode),
        .ID_IN            (id_in),
        .VC_EMPTY         (vc_empty),
        .VC_DATA          (vc_data),
        .MAIN_ALMOST_FULL (main_af),
        .MAIN_FULL        (main_full),
        .VC_POP           (vc_pop),
        .MAIN_PUSH        (main_push),
        .MAIN_DATA        (main_data),
        .CUR_ID           (cur_id),
        .XFER_COUNT       (xfer_count),
        .OVF_ERR          (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT channel FIFO models.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            vc_empty[i]          = (rd[i] == wr[i]);
            vc_data[i*DW +: DW]  = fifo[i][rd[i] % 8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (vc_pop[i] && (rd[i] != wr[i])) rd[i] <= rd[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int ch, input logic [DW-1:0] w);
        fifo[ch][wr[ch] % 8] = w;
        wr[ch]++;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NCH; i++) wr[i] = rd[i];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        mode      = 1'b0;
        id_in     = '0;
        main_af   = 1'b0;
        main_full = 1'b0;
        clear_fifos();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int rr_seq [12];
        int er_seq [5];
        rr_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
        er_seq = '{1, 3, 3, 3, 3};
        for (int i = 0; i < NCH; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end

        // Reset values.
        do_reset();
        #1;
        chk("rst_pop",  32'(vc_pop),     32'h0);
        chk("rst_push", 32'(main_push),  32'h0);
        chk("rst_data", 32'(main_data),  32'h0);
        chk("rst_cid",  32'(cur_id),     32'h0);
        chk("rst_xfer", 32'(xfer_count), 32'h0);
        chk("rst_ovf",  32'(ovf_err),    32'h0);

        // Forced mode: VC2 holds A, B.
        do_reset();
        push_word(2, 4'hA);
        push_word(2, 4'hB);
        mode = 1'b0; id_in = 2'd2; enable = 1'b1;
        #1;
        chk("f_pop0", 32'(vc_pop), 32'b0100);
        tick();
        chk("f_pop1",  32'(vc_pop),    32'b0100);
        chk("f_push1", 32'(main_push), 32'h1);
        chk("f_data1", 32'(main_data), 32'hA);
        chk("f_cid1",  32'(cur_id),    32'h2);
        tick();
        chk("f_pop2",  32'(vc_pop),     32'h0);
        chk("f_push2", 32'(main_push),  32'h1);
        chk("f_data2", 32'(main_data),  32'hB);
        chk("f_xfer2", 32'(xfer_count), 32'h1);
        tick();
        chk("f_push3", 32'(main_push),  32'h0);
        chk("f_xfer3", 32'(xfer_count), 32'h2);
        chk("f_cid3",  32'(cur_id),     32'h2);

        // Round-robin, BURST=2, four channels with three words each.
        do_reset();
        for (int ch = 0; ch < NCH; ch++)
            for (int k = 0; k < 3; k++) push_word(ch, 4'(ch * 3 + k + 1));
        mode = 1'b1; enable = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("rr_g%0d", c), 32'(vc_pop), 32'(1 << rr_seq[c]));
            if (c == 1) begin
                chk("rr_push1", 32'(main_push), 32'h1);
                chk("rr_data1", 32'(main_data), 32'h1);
            end
            tick();
        end
        chk("rr_idle",  32'(vc_pop),    32'h0);
        chk("rr_last",  32'(main_data), 32'hC);
        chk("rr_cid",   32'(cur_id),    32'h3);

        // Early rotation: VC1 one word, VC3 four words.
        do_reset();
        push_word(1, 4'h1);
        for (int k = 0; k < 4; k++) push_word(3, 4'(k + 2));
        mode = 1'b1; enable = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("er_g%0d", c), 32'(vc_pop), 32'(1 << er_seq[c]));
            tick();
        end
        chk("er_idle", 32'(vc_pop), 32'h0);

        // Backpressure, overflow, then reset mid-stream.
        do_reset();
        for (int k = 0; k < 8; k++) push_word(0, 4'(k + 1));
        mode = 1'b0; id_in = 2'd0; enable = 1'b1;
        #1;
        chk("bp_pop0", 32'(vc_pop), 32'b0001);
        tick();
        chk("bp_pop1", 32'(vc_pop), 32'b0001);
        tick();
        main_af = 1'b1;
        #1;
        chk("bp_af_pop",   32'(vc_pop),    32'h0);
        chk("bp_af_push",  32'(main_push), 32'h1);
        chk("bp_af_data",  32'(main_data), 32'h2);
        tick();
        chk("bp_hold_pop",  32'(vc_pop),    32'h0);
        chk("bp_hold_push", 32'(main_push), 32'h0);
        main_af = 1'b0;
        #1;
        chk("bp_resume", 32'(vc_pop), 32'b0001);
        tick();
        chk("bp_data3",  32'(main_data), 32'h3);
        chk("ovf_pre",   32'(ovf_err),   32'h0);
        main_full = 1'b1;
        tick();
        chk("ovf_set",   32'(ovf_err),   32'h1);
        main_full = 1'b0;
        tick();
        tick();
        chk("ovf_hold",  32'(ovf_err),    32'h1);
        chk("ms_push",   32'(main_push),  32'h1);
        chk("ms_xfer",   32'(xfer_count), 32'h1);
        rst = 1'b1;
        #1;
        chk("ms_pop",    32'(vc_pop),     32'h0);
        chk("ms_push0",  32'(main_push),  32'h0);
        chk("ms_data0",  32'(main_data),  32'h0);
        chk("ms_cid0",   32'(cur_id),     32'h0);
        chk("ms_xfer0",  32'(xfer_count), 32'h0);
        chk("ms_ovf0",   32'(ovf_err),    32'h0);
        tick();
        rst = 1'b0;
        push_word(2, 4'h9);
        mode = 1'b1;
        #1;
        chk("ms_first_rr", 32'(vc_pop), 32'b0001);

        // Counter wrap with CW=2: five transfers leave 1.
        do_reset();
        for (int k = 0; k < 5; k++) push_word(1, 4'(k + 4));
        mode = 1'b0; id_in = 2'd1; enable = 1'b1;
        repeat (7) tick();
        chk("wrap_xfer", 32'(xfer_count), 32'h1);
        chk("wrap_cid",  32'(cur_id),     32'h1);
        chk("wrap_data", 32'(main_data),  32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
